ysyx_23060077_ifu: RTL and testbench

YSYX_23060077_IFU -- requirements
Module: ysyx_23060077_ifu

---
 rtl/ysyx_23060077_ifu.sv | 113 +++++++++++
 tb/tb_ysyx_23060077_ifu.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060077_ifu.sv
// Instruction fetch unit: single-outstanding fetch FSM (S_REQ -> S_WAIT -> S_OUT).
// Redirects can arrive in any state; a redirect in S_WAIT drops the in-flight response.
module ysyx_23060077_ifu #(
    parameter int unsigned      XLEN     = 32,
    parameter logic [XLEN-1:0]  RESET_PC = XLEN'(32'h3000_0000)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [XLEN-1:0] mem_req_addr,
    input  logic            mem_resp_valid,
    input  logic [XLEN-1:0] mem_resp_data,
    input  logic            mem_resp_err,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc,
    output logic            inst_fault
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [XLEN-1:0] pc, pc_nxt;
    logic            discard, discard_nxt;
    logic            load_inst;

    assign mem_req_addr = pc;

    always_ff @(posedge clock) begin
        if (reset) state <= S_REQ;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        pc_nxt        = pc;
        discard_nxt   = discard;
        load_inst     = 1'b0;
        mem_req_valid = 1'b0;
        inst_valid    = 1'b0;
        case (state)
            S_REQ: begin
                mem_req_valid = ~redirect_valid;
                if (redirect_valid)     pc_nxt    = redirect_pc;
                else if (mem_req_ready) state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (redirect_valid) begin
                    pc_nxt = redirect_pc;
                    // A response in the same cycle is the one being dropped, so
                    // there is nothing left to discard.
                    if (mem_resp_valid) begin
                        state_nxt   = S_REQ;
                        discard_nxt = 1'b0;
                    end else begin
                        discard_nxt = 1'b1;
                    end
                end else if (mem_resp_valid) begin
                    discard_nxt = 1'b0;
                    if (discard) begin
                        state_nxt = S_REQ;
                    end else begin
                        load_inst = 1'b1;
                        state_nxt = S_OUT;
                    end
                end
            end
            S_OUT: begin
                inst_valid = ~redirect_valid;
                if (redirect_valid) begin
                    pc_nxt    = redirect_pc;
                    state_nxt = S_REQ;
                end else if (inst_ready) begin
                    pc_nxt    = pc + XLEN'(4);
                    state_nxt = S_REQ;
                end
            end
            default: state_nxt = S_REQ;
        endcase
        // Handshakes stay quiet for the whole reset cycle, whatever the old state.
        if (reset) begin
            mem_req_valid = 1'b0;
            inst_valid    = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pc         <= RESET_PC;
            discard    <= 1'b0;
            inst       <= '0;
            inst_pc    <= '0;
            inst_fault <= 1'b0;
        end else begin
            pc      <= pc_nxt;
            discard <= discard_nxt;
            if (load_inst) begin
                inst       <= mem_resp_data;
                inst_pc    <= pc;
                inst_fault <= mem_resp_err;
            end
        end
    end

endmodule

// File: tb/tb_ysyx_23060077_ifu.sv
// Cycle-by-cycle directed vectors for the fetch unit, plus hand sequences for reset.
module tb_ysyx_23060077_ifu;

    logic        clock = 1'b0;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;
    logic        mem_resp_err;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_fault;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    ysyx_23060077_ifu dut (
        .clock          (clock),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data),
        .mem_resp_err   (mem_resp_err),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_fault     (inst_fault)
    );

    typedef struct {
        logic        rv;
        logic [31:0] rpc;
        logic        rdy;
        logic        rsv;
        logic [31:0] rdata;
        logic        rerr;
        logic        ird;
        logic        e_rqv;
        logic [31:0] e_addr;
        logic        e_iv;
        logic [31:0] e_inst;
        logic [31:0] e_ipc;
        logic        e_flt;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic rv, input logic [31:0] rpc, input logic rdy,
                       input logic rsv, input logic [31:0] rdata, input logic rerr,
                       input logic ird, input logic e_rqv, input logic [31:0] e_addr,
                       input logic e_iv, input logic [31:0] e_inst,
                       input logic [31:0] e_ipc, input logic e_flt);
        vec_t v;
        v.rv = rv; v.rpc = rpc; v.rdy = rdy; v.rsv = rsv; v.rdata = rdata;
        v.rerr = rerr; v.ird = ird; v.e_rqv = e_rqv; v.e_addr = e_addr;
        v.e_iv = e_iv; v.e_inst = e_inst; v.e_ipc = e_ipc; v.e_flt = e_flt;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic chk_all(input int idx, input logic rqv, input logic [31:0] addr,
                           input logic iv, input logic [31:0] ins,
                           input logic [31:0] ipc, input logic flt);
        chk("mem_req_valid", idx, {31'd0, mem_req_valid}, {31'd0, rqv});
        chk("mem_req_addr",  idx, mem_req_addr, addr);
        chk("inst_valid",    idx, {31'd0, inst_valid}, {31'd0, iv});
        chk("inst",          idx, inst, ins);
        chk("inst_pc",       idx, inst_pc, ipc);
        chk("inst_fault",    idx, {31'd0, inst_fault}, {31'd0, flt});
    endtask

    task automatic idle_inputs();
        redirect_valid = 1'b0; redirect_pc = '0; mem_req_ready = 1'b0;
        mem_resp_valid = 1'b0; mem_resp_data = '0; mem_resp_err = 1'b0;
        inst_ready = 1'b0;
    endtask

    localparam logic [31:0] B = 32'h3000_0000;

    initial begin
        // rv rpc rdy rsv rdata rerr ird | rqv addr iv inst ipc flt
        // Fetch, deliver, advance
        add(0, 0,        1, 0, 0,            0, 0,  1, B,       0, 0,            0,       0);
        add(0, 0,        0, 1, 32'h13,       0, 0,  0, B,       0, 0,            0,       0);
        add(0, 0,        0, 0, 0,            0, 1,  0, B,       1, 32'h13,       B,       0);
        add(0, 0,        0, 0, 0,            0, 0,  1, B+4,     0, 32'h13,       B,       0);
        // Back-pressure for 5 cycles with bus noise; nothing moves
        add(0, 0,        1, 0, 0,            0, 0,  1, B+4,     0, 32'h13,       B,       0);
        add(0, 0,        0, 1, 32'h93,       0, 0,  0, B+4,     0, 32'h13,       B,       0);
        for (int i = 0; i < 5; i++)
            add(0, 0,    1, 1, 32'hFFFF_FFFF, 1, 0, 0, B+4,     1, 32'h93,       B+4,     0);
        add(0, 0,        0, 0, 0,            0, 1,  0, B+4,     1, 32'h93,       B+4,     0);
        // Two redirects while waiting: last wins, late response dropped
        add(0, 0,        1, 0, 0,            0, 0,  1, B+8,     0, 32'h93,       B+4,     0);
        add(1, B+32'h200,0, 0, 0,            0, 0,  0, B+8,     0, 32'h93,       B+4,     0);
        add(1, B+32'h100,0, 0, 0,            0, 0,  0, B+32'h200,0, 32'h93,      B+4,     0);
        add(0, 0,        0, 0, 0,            0, 0,  0, B+32'h100,0, 32'h93,      B+4,     0);
        add(0, 0,        0, 1, 32'hDEAD_BEEF,0, 1,  0, B+32'h100,0, 32'h93,      B+4,     0);
        add(0, 0,        0, 0, 0,            0, 1,  1, B+32'h100,0, 32'h93,      B+4,     0);
        add(0, 0,        1, 0, 0,            0, 0,  1, B+32'h100,0, 32'h93,      B+4,     0);
        // Redirect coincident with the response
        add(1, B+32'h40, 0, 1, 32'h1234_5678,0, 1,  0, B+32'h100,0, 32'h93,      B+4,     0);
        add(0, 0,        1, 0, 0,            0, 0,  1, B+32'h40, 0, 32'h93,      B+4,     0);
        // Bus error delivered as a faulting instruction
        add(0, 0,        0, 1, 32'h0010_0073,1, 0,  0, B+32'h40, 0, 32'h93,      B+4,     0);
        add(0, 0,        0, 0, 0,            0, 1,  0, B+32'h40, 1, 32'h0010_0073,B+32'h40,1);
        // Redirect in S_REQ suppresses the request
        add(1, B+32'h80, 1, 0, 0,            0, 0,  0, B+32'h44, 0, 32'h0010_0073,B+32'h40,1);
        add(0, 0,        1, 0, 0,            0, 0,  1, B+32'h80, 0, 32'h0010_0073,B+32'h40,1);
        add(0, 0,        0, 1, 32'h513,      0, 0,  0, B+32'h80, 0, 32'h0010_0073,B+32'h40,1);
        // Redirect in S_OUT drops the buffered instruction
        add(1, B+32'h20, 0, 0, 0,            0, 1,  0, B+32'h80, 0, 32'h513,     B+32'h80,0);
        add(0, 0,        0, 0, 0,            0, 0,  1, B+32'h20, 0, 32'h513,     B+32'h80,0);
        add(0, 0,        1, 0, 0,            0, 0,  1, B+32'h20, 0, 32'h513,     B+32'h80,0);

        // Power-on reset
        idle_inputs();
        reset = 1'b1;
        @(posedge clock); #1;
        @(negedge clock);
        chk_all(-1, 0, B, 0, 0, 0, 0);
        @(posedge clock); #1;
        reset = 1'b0;

        foreach (tbl[i]) begin
            redirect_valid = tbl[i].rv;   redirect_pc   = tbl[i].rpc;
            mem_req_ready  = tbl[i].rdy;  mem_resp_valid = tbl[i].rsv;
            mem_resp_data  = tbl[i].rdata; mem_resp_err  = tbl[i].rerr;
            inst_ready     = tbl[i].ird;
            @(negedge clock);
            chk_all(i, tbl[i].e_rqv, tbl[i].e_addr, tbl[i].e_iv,
                    tbl[i].e_inst, tbl[i].e_ipc, tbl[i].e_flt);
            @(posedge clock); #1;
        end

        // Reset while a fetch is outstanding (DUT now in S_WAIT)
        idle_inputs();
        reset = 1'b1;
        @(negedge clock);
        chk_all(100, 0, B+32'h20, 0, 32'h513, B+32'h80, 0);
        @(posedge clock); #1;
        reset = 1'b0;
        mem_resp_valid = 1'b1; mem_resp_data = 32'hCAFE_BABE;
        @(negedge clock);
        chk_all(101, 1, B, 0, 0, 0, 0);
        @(posedge clock); #1;
        idle_inputs();
        @(negedge clock);
        chk_all(102, 1, B, 0, 0, 0, 0);
        @(posedge clock); #1;
        mem_req_ready = 1'b1;
        @(posedge clock); #1;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_resp_data = 32'h0000_0113;
        @(posedge clock); #1;
        idle_inputs();
        @(negedge clock);
        chk_all(103, 0, B, 1, 32'h113, B, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
